ntt_stage_controller: RTL and testbench
=======================================

# ntt_stage_controller

Issue-side sequencer for the mixed-radix NTT core. On a `start` pulse it walks the three butterfly stages (p = 2, 1, 0) and, per cycle, emits the stage index `p`, group index `k` and in-group butterfly index `j`. `p` and `k` feed the twiddle-factor address generator directly; `j` and `k` feed the data-memory address path. Stages are separated by a fixed write-back gap, and the block reports completion with a `done` pulse.

## Interface
- `STAGE_GAP`, default 2: idle cycles inserted between stages for memory write-back (legal range 0..15).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-low.
- `start`  in  1  single-cycle request to run one full transform. Honoured only in IDLE.
- `stall`  in  1  downstream back-pressure. While high in RUN, the current issue is held.
- `mode`  in  1  0 = NTT, 1 = INTT. Present only with `INTT_EN`.
- `p`  out  4  stage index (2, 1 or 0).
- `k`  out  5  group index within the stage.
- `j`  out  5  butterfly index within the group.
- `valid`  out  1  `p`/`k`/`j` carry a live issue.
- `busy`  out  1  a transform is in progress.
- `done`  out  1  one-cycle pulse after the last issue.

## Operation
- Stage geometry: group count G(p) and butterflies per group B(p).
  - p=2: G=2, B=32.
  - p=1: G=8, B=8.
  - p=0: G=32, B=2.
  - Every stage issues exactly 64 butterflies.
- States and transitions:
  - IDLE: outputs zeroed. `start` → RUN, with the first stage loaded.
  - RUN: one issue per non-stalled cycle.
    - `j` increments; when it wraps at B(p)-1, `k` increments.
    - When `k`=G(p)-1 and `j`=B(p)-1 are issued: go to GAP if more stages remain, otherwise go to DONE.
  - GAP: `valid`=0. Count STAGE_GAP cycles, then go to RUN with the next `p`, `k`=0, `j`=0. With STAGE_GAP=0, RUN goes straight into the next stage with no bubble.
  - DONE: `done`=1, `busy`=0, `valid`=0 for one cycle, then → IDLE.
- Stall rule:
  - `stall` in RUN freezes `p`/`k`/`j` and keeps `valid`=1. The held issue counts as issued only on the cycle where `stall`=0.
  - `stall` is ignored in IDLE, GAP and DONE. The GAP counter keeps running.
- Ignored or aborting events:
  - `start` while not in IDLE (including the DONE cycle) is ignored. No queuing.
  - `start` and `stall` high together in IDLE: start the transform; the first issue is then held by the stall.
  - Reset asserted mid-transform aborts immediately. No `done` pulse is produced.
- Counter widths: `k`/`j` are 5-bit with no overflow. Maximum values are `k`=31 and `j`=31.

## Timing
- All outputs are registered.
- Reset values: `p`=0, `k`=0, `j`=0, `valid`=0, `busy`=0, `done`=0, state = IDLE.
- Start latency: `start` sampled at edge N makes the first issue (`p`=2, `k`=0, `j`=0, `valid`=1, `busy`=1) visible after edge N, i.e. in cycle N+1.
- Unstalled, STAGE_GAP=2, counting cycles from N+1:
  - Stage 2 issues in cycles 1–64.
  - Gap in cycles 65–66.
  - Stage 1 issues in cycles 67–130.
  - Gap in cycles 131–132.
  - Stage 0 issues in cycles 133–196.
  - `done` in cycle 197.
- General: total = 192 + 2·STAGE_GAP + stalled cycles, then the `done` cycle.
- `busy` is high from the first issue cycle through the last issue (including GAP cycles) and is low in the `done` cycle.
- The twiddle address generator registers its output, so consumers must delay `valid` by one cycle to align it with the twiddle address.

## Configuration
- `INTT_EN` defined: the `mode` port exists.
  - `mode` is sampled together with `start`.
  - `mode`=1 reverses stage order to p = 0, 1, 2. G/B per stage are unchanged.
  - `mode` changes during a run are ignored.
- `INTT_EN` undefined: no `mode` port; the stage order is always 2, 1, 0.

## Test plan
- Reset then `start` with no stall: 64 issues per stage in order p=2,1,0, gaps in cycles 65–66 and 131–132, `done` in cycle 197; first tuples (2,0,0),(2,0,1); last tuple (0,31,1).
- Wrap boundaries: after (2,0,31) the next issue is (2,1,0); after (1,7,7) `valid` drops for STAGE_GAP cycles, then (0,0,0) is issued.
- `stall` high for 3 cycles at issue (1,3,5): tuple held with `valid`=1; the next issue is (1,3,6); `done` moves to cycle 200.
- `start` pulsed during RUN and during the DONE cycle: ignored, no restart. `start` one cycle after DONE launches a new run.
- Reset asserted at issue (1,2,0): all outputs go to 0 asynchronously and no `done` pulse occurs. After release, `start` runs a full 197-cycle transform.
- With `INTT_EN`, `mode`=1: first issue (0,0,0), last issue (2,1,31), `done` in cycle 197.

Source files
------------

// File: rtl/ntt_stage_controller.sv
// Issue-side sequencer for the three-stage mixed-radix NTT: walks p/k/j per stage with a write-back gap.
// Optional INTT_EN adds an i_mode port that reverses the stage order (p = 0, 1, 2).
module ntt_stage_controller #(
  parameter int STAGE_GAP = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_stall,
`ifdef INTT_EN
  input  logic       i_mode,
`endif
  output logic [3:0] o_p,
  output logic [4:0] o_k,
  output logic [4:0] o_j,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_state
);

  // Handshake: o_valid=1 means p/k/j is a live issue; it is consumed on a cycle
  // where i_stall=0, otherwise it is held unchanged on the next cycle.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

  state_t     r_state;
  logic [3:0] r_p;
  logic [4:0] r_k;
  logic [4:0] r_j;
  logic       r_valid;
  logic       r_busy;
  logic       r_done;
  logic [1:0] r_stage;
  logic [3:0] r_gap_cnt;
  logic       r_inv;

  logic       w_mode;
  logic       w_last_j;
  logic       w_last_k;
  logic       w_last_stage;
  logic [3:0] w_next_p;

  function automatic logic [3:0] stage_p(input logic [1:0] idx, input logic inv);
    return inv ? {2'b00, idx} : {2'b00, 2'd2 - idx};
  endfunction

  function automatic logic [4:0] grp_last(input logic [3:0] p);
    case (p)
      4'd2:    return 5'd1;
      4'd1:    return 5'd7;
      default: return 5'd31;
    endcase
  endfunction

  function automatic logic [4:0] bfly_last(input logic [3:0] p);
    case (p)
      4'd2:    return 5'd31;
      4'd1:    return 5'd7;
      default: return 5'd1;
    endcase
  endfunction

`ifdef INTT_EN
  assign w_mode = i_mode;
`else
  assign w_mode = 1'b0;
`endif

  assign w_last_j     = (r_j == bfly_last(r_p));
  assign w_last_k     = (r_k == grp_last(r_p));
  assign w_last_stage = (r_stage == 2'd2);
  assign w_next_p     = stage_p(r_stage + 2'd1, r_inv);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_p       <= '0;
      r_k       <= '0;
      r_j       <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_stage   <= '0;
      r_gap_cnt <= '0;
      r_inv     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_RUN;
            r_inv   <= w_mode;
            r_stage <= 2'd0;
            r_p     <= stage_p(2'd0, w_mode);
            r_k     <= '0;
            r_j     <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (!i_stall) begin
            if (!w_last_j) begin
              r_j <= r_j + 5'd1;
            end else begin
              r_j <= '0;
              if (!w_last_k) begin
                r_k <= r_k + 5'd1;
              end else begin
                r_k <= '0;
                if (w_last_stage) begin
                  r_state <= S_DONE;
                  r_p     <= '0;
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end else begin
                  r_stage <= r_stage + 2'd1;
                  r_p     <= w_next_p;
                  // A zero gap chains stages back to back without a bubble.
                  if (STAGE_GAP != 0) begin
                    r_state   <= S_GAP;
                    r_valid   <= 1'b0;
                    r_gap_cnt <= 4'(STAGE_GAP - 1);
                  end
                end
              end
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == 4'd0) begin
            r_state <= S_RUN;
            r_valid <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_p     = r_p;
  assign o_k     = r_k;
  assign o_j     = r_j;
  assign o_valid = r_valid;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_state = r_state;

endmodule

// File: tb/tb_ntt_stage_controller.sv
// Bench for ntt_stage_controller: table of spot checks, trace model over whole runs, reset-abort sequence.
module tb_ntt_stage_controller;
  localparam int GAP = 2;
  localparam int CAP = 420;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stall;
  logic       mode;
  logic [3:0] o_p;
  logic [4:0] o_k;
  logic [4:0] o_j;
  logic       o_valid;
  logic       o_busy;
  logic       o_done;
  logic [1:0] o_state;

  always #5 clk = ~clk;

  ntt_stage_controller #(.STAGE_GAP(GAP)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_stall (stall),
`ifdef INTT_EN
    .i_mode  (mode),
`endif
    .o_p     (o_p),
    .o_k     (o_k),
    .o_j     (o_j),
    .o_valid (o_valid),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_state (o_state)
  );

  // Expected word: {care_tuple, valid, busy, done, p[3:0], k[4:0], j[4:0]}
  logic        stall_pat[CAP];
  logic        start_pat[CAP];
  logic [16:0] obs[CAP];
  logic [17:0] exp_q[$];
  int          tests;
  int          fails;

  typedef struct {
    string       name;
    int          stall_at;
    int          stall_len;
    int          start2;
    logic        m;
    int          cyc;
    logic [17:0] exp;
  } vec_t;
  vec_t vq[$];

  function automatic logic [17:0] mk(input logic care, input logic v, input logic b,
                                     input logic d, input int p, input int k, input int j);
    return {care, v, b, d, 4'(p), 5'(k), 5'(j)};
  endfunction

  function automatic logic [16:0] cur_out();
    return {o_valid, o_busy, o_done, o_p, o_k, o_j};
  endfunction

  task automatic check(input string nm, input int cyc, input logic [16:0] act, input logic [17:0] e);
    logic [16:0] mask;
    mask = e[17] ? 17'h1FFFF : 17'h1C000;
    tests++;
    if ((act & mask) !== (e[16:0] & mask)) begin
      fails++;
      $display("FAIL %s cyc %0d: got v/b/d=%b p=%0d k=%0d j=%0d, want v/b/d=%b p=%0d k=%0d j=%0d",
               nm, cyc, act[16:14], act[13:10], act[9:5], act[4:0],
               e[16:14], e[13:10], e[9:5], e[4:0]);
    end
  endtask

  task automatic add(input string nm, input int sa, input int sl, input int s2, input logic m,
                     input int cyc, input logic [17:0] e);
    vec_t v;
    v.name = nm; v.stall_at = sa; v.stall_len = sl; v.start2 = s2;
    v.m = m; v.cyc = cyc; v.exp = e;
    vq.push_back(v);
  endtask

  task automatic clear_pats();
    for (int t = 0; t < CAP; t++) begin
      stall_pat[t] = 1'b0;
      start_pat[t] = 1'b0;
    end
  endtask

  // Cycle 0 is the start cycle (DUT idle); obs[c] is sampled mid-cycle c.
  task automatic capture_run(input logic m);
    for (int c = 0; c < CAP; c++) begin
      @(negedge clk);
      obs[c] = cur_out();
      start  = (c == 0) || start_pat[c];
      stall  = stall_pat[c];
      mode   = (c == 0) ? m : 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  // Reference: list the issues stage by stage, repeat each while stalled, add gaps and the done cycle.
  task automatic build_expected(input logic m);
    int order[3];
    int c;
    int g;
    int b;
    exp_q.delete();
    for (int s = 0; s < 3; s++) order[s] = m ? s : 2 - s;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    c = 1;
    for (int s = 0; s < 3; s++) begin
      g = (order[s] == 2) ? 2 : (order[s] == 1) ? 8 : 32;
      b = 64 / g;
      for (int k = 0; k < g; k++) begin
        for (int j = 0; j < b; j++) begin
          exp_q.push_back(mk(1, 1, 1, 0, order[s], k, j));
          while (c < CAP && stall_pat[c]) begin
            c++;
            exp_q.push_back(mk(1, 1, 1, 0, order[s], k, j));
          end
          c++;
        end
      end
      if (s < 2) begin
        for (int t = 0; t < GAP; t++) begin
          exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0));
          c++;
        end
      end
    end
    exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic compare_run(input string nm);
    for (int i = 0; i < exp_q.size() && i < CAP; i++) check(nm, i, obs[i], exp_q[i]);
  endtask

  initial begin
    int   p_sa, p_sl, p_s2;
    logic p_m;
    logic m;
    logic done_seen;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    mode  = 1'b0;
    clear_pats();

    // Spot-check table (cycle numbers counted from the start cycle = 0).
    add("reset_idle",   -1, 0, -1, 0,   0, mk(1, 0, 0, 0, 0, 0, 0));
    add("first_issue",  -1, 0, -1, 0,   1, mk(1, 1, 1, 0, 2, 0, 0));
    add("second_issue", -1, 0, -1, 0,   2, mk(1, 1, 1, 0, 2, 0, 1));
    add("j_max",        -1, 0, -1, 0,  32, mk(1, 1, 1, 0, 2, 0, 31));
    add("k_increment",  -1, 0, -1, 0,  33, mk(1, 1, 1, 0, 2, 1, 0));
    add("gap1_a",       -1, 0, -1, 0,  65, mk(0, 0, 1, 0, 0, 0, 0));
    add("gap1_b",       -1, 0, -1, 0,  66, mk(0, 0, 1, 0, 0, 0, 0));
    add("stage1_first", -1, 0, -1, 0,  67, mk(1, 1, 1, 0, 1, 0, 0));
    add("stage1_last",  -1, 0, -1, 0, 130, mk(1, 1, 1, 0, 1, 7, 7));
    add("gap2_a",       -1, 0, -1, 0, 131, mk(0, 0, 1, 0, 0, 0, 0));
    add("gap2_b",       -1, 0, -1, 0, 132, mk(0, 0, 1, 0, 0, 0, 0));
    add("stage0_first", -1, 0, -1, 0, 133, mk(1, 1, 1, 0, 0, 0, 0));
    add("last_issue",   -1, 0, -1, 0, 196, mk(1, 1, 1, 0, 0, 31, 1));
    add("done_pulse",   -1, 0, -1, 0, 197, mk(0, 0, 0, 1, 0, 0, 0));
    add("idle_after",   -1, 0, -1, 0, 198, mk(1, 0, 0, 0, 0, 0, 0));
    add("stall_held0",  96, 3, -1, 0,  96, mk(1, 1, 1, 0, 1, 3, 5));
    add("stall_held3",  96, 3, -1, 0,  99, mk(1, 1, 1, 0, 1, 3, 5));
    add("stall_next",   96, 3, -1, 0, 100, mk(1, 1, 1, 0, 1, 3, 6));
    add("stall_last",   96, 3, -1, 0, 199, mk(1, 1, 1, 0, 0, 31, 1));
    add("stall_done",   96, 3, -1, 0, 200, mk(0, 0, 0, 1, 0, 0, 0));
    add("start_stall",   0, 2, -1, 0,   2, mk(1, 1, 1, 0, 2, 0, 0));
    add("start_stall2",  0, 2, -1, 0,   3, mk(1, 1, 1, 0, 2, 0, 1));
    add("start_in_run", -1, 0, 100, 0, 101, mk(1, 1, 1, 0, 1, 4, 2));
    add("start_in_done",-1, 0, 197, 0, 198, mk(1, 0, 0, 0, 0, 0, 0));
    add("restart",      -1, 0, 198, 0, 199, mk(1, 1, 1, 0, 2, 0, 0));
    add("restart_done", -1, 0, 198, 0, 395, mk(0, 0, 0, 1, 0, 0, 0));
`ifdef INTT_EN
    add("intt_first",   -1, 0, -1, 1,   1, mk(1, 1, 1, 0, 0, 0, 0));
    add("intt_last",    -1, 0, -1, 1, 196, mk(1, 1, 1, 0, 2, 1, 31));
    add("intt_done",    -1, 0, -1, 1, 197, mk(0, 0, 0, 1, 0, 0, 0));
`endif

    repeat (3) @(negedge clk);
    check("in_reset", 0, cur_out(), mk(1, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;

    p_sa = -2; p_sl = -2; p_s2 = -2; p_m = 1'b0;
    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].stall_at != p_sa || vq[i].stall_len != p_sl ||
          vq[i].start2 != p_s2 || vq[i].m != p_m) begin
        p_sa = vq[i].stall_at; p_sl = vq[i].stall_len; p_s2 = vq[i].start2; p_m = vq[i].m;
        clear_pats();
        if (p_sa >= 0) for (int t = p_sa; t < p_sa + p_sl; t++) stall_pat[t] = 1'b1;
        if (p_s2 >= 0) start_pat[p_s2] = 1'b1;
        capture_run(p_m);
        if (p_s2 < 198) begin
          build_expected(p_m);
          compare_run({"model_", vq[i].name});
        end
      end
      check(vq[i].name, vq[i].cyc, obs[vq[i].cyc], vq[i].exp);
    end

    // Randomly stalled transforms against the trace model.
    for (int r = 0; r < 4; r++) begin
      clear_pats();
      for (int t = 0; t < 200; t++) stall_pat[t] = ($urandom_range(0, 7) == 0);
`ifdef INTT_EN
      m = 1'($urandom_range(0, 1));
`else
      m = 1'b0;
`endif
      capture_run(m);
      build_expected(m);
      compare_run("random_run");
    end

    // Asynchronous abort at issue (1,2,0), then a clean full run.
    clear_pats();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (82) @(negedge clk);
    check("abort_point", 83, cur_out(), mk(1, 1, 1, 0, 1, 2, 0));
    #2 rst_n = 1'b0;
    #1 check("abort_async", 83, cur_out(), mk(1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int c = 0; c < 250; c++) begin
      @(negedge clk);
      done_seen = done_seen | o_done;
    end
    check("abort_no_done", 0, {2'b00, done_seen, 14'd0}, mk(1, 0, 0, 0, 0, 0, 0));
    capture_run(1'b0);
    build_expected(1'b0);
    compare_run("after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
